scarv_rng_arbiter: RTL and testbench
====================================

Name: scarv_rng_arbiter

Overview:
- Shares one RNG (scarv-cpu randomness interface: valid/ready request, valid/ready response with status and data) between two requesters.
- Requester 0 is the CPU; requester 1 is a secondary consumer (e.g. a masking or DMA engine).
- Round-robin arbitration. One transaction in flight at a time. The response is registered and routed back to the owning requester.
- Sits between the requesters and the RNG instance in the SoC top level.

Parameters:
- SEED_MASK, 2'b01: bit i set means requester i may issue OP_SEED (3'b001).
- TIMEOUT_CYCLES, 16'd255: watchdog limit, in cycles, for the RNG to respond (used only with the optional feature).

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  synchronous reset, active-low
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_op  in  6  ops, requester i at [3i+2:3i]
- req_data  in  64  seed data, requester i at [32i+31:32i]
- req_ready  out  2  request accepted
- rsp_valid  out  2  response valid to requester i
- rsp_status  out  3  response status, shared, qualified by rsp_valid
- rsp_data  out  32  response data, shared, qualified by rsp_valid
- rsp_ready  in  2  requester i accepts response
- rng_req_valid  out  1  request to RNG
- rng_req_op  out  3  latched op
- rng_req_data  out  32  latched data
- rng_req_ready  in  1  RNG accepts request
- rng_rsp_valid  in  1  RNG response valid
- rng_rsp_status  in  3  RNG status
- rng_rsp_data  in  32  RNG data
- rng_rsp_ready  out  1  arbiter accepts RNG response

Behaviour:
- Reset: state IDLE; last_grant=1 so requester 0 wins the first tie; owner=0; op/data/status/rsp registers = 0. All outputs 0.
- Status codes: HEALTHY=3'b101, UNHEALTHY=3'b100, NO_INIT=3'b000.
- Arbitration (IDLE only): if exactly one req_valid bit is set, that requester wins. If both are set, the requester != last_grant wins.
- IDLE:
  - req_ready[win]=1 combinationally in the same cycle as its req_valid. Nothing else is asserted.
  - The accepted request latches owner, op and data.
  - If op==OP_SEED and SEED_MASK[win]==0: do not issue downstream; set status=UNHEALTHY, data=0; go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - rng_req_valid=1 with the latched op/data, held stable until rng_req_ready. rng_rsp_ready=1.
  - On rng_req_ready with rng_rsp_valid in the same cycle: capture status/data and go to RESP.
  - On rng_req_ready alone: go to WAIT.
- WAIT: rng_rsp_ready=1. On rng_rsp_valid, capture status/data and go to RESP.
- RESP:
  - rsp_valid[owner]=1; rsp_status/rsp_data come from registers and are stable.
  - On rsp_ready[owner]: last_grant<=owner, go to IDLE.
  - A new request can be accepted no earlier than the following cycle.
- rng_rsp_ready=0 and rng_req_valid=0 outside ISSUE/WAIT. A stray rng_rsp_valid in IDLE/RESP is ignored.
- Minimum latency with a zero-latency RNG: request accepted at cycle 0, rsp_valid at cycle 2. Peak throughput is one transaction per 3 cycles.
- The non-owner's req_valid is ignored (req_ready=0) until the arbiter returns to IDLE. Requesters hold valid/op/data until they see req_ready.
- Reset mid-transaction returns to IDLE the next cycle and drops the in-flight response. The RNG sees rng_req_valid fall, which is legal because the RNG is reset by the same g_resetn.
- rsp_valid never has both bits set. Outputs are pure functions of state, owner and registers, except req_ready, which also depends on req_valid.

Optional Feature:
- Macro: SCARV_RNG_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT.
  - When it equals TIMEOUT_CYCLES with no response captured: rng_req_valid drops, status=UNHEALTHY, data=0, go to RESP.
  - A late RNG response is ignored per the stray rule.
- When undefined: no counter exists and ISSUE/WAIT wait indefinitely.

Test Plan:
- Zero-latency RNG; req_valid=2'b01, op=OP_SAMP -> req_ready=2'b01 at cycle 0; rng_req_valid at cycle 1; rsp_valid=2'b01 at cycle 2 with status 3'b101 and the RNG data.
- Both valid every cycle for 6 transactions, rsp_ready tied 1 -> grants alternate 0,1,0,1,0,1 and each rsp_valid bit matches the owner.
- Requester 1 issues OP_SEED with data 32'h12345678 (SEED_MASK=2'b01) -> no rng_req_valid; rsp_valid=2'b10, status 3'b100, data 0. The same request from requester 0 is forwarded with rng_req_data=32'h12345678.
- RNG with rng_req_ready low 3 cycles, then rsp 4 cycles after acceptance; requester holds rsp_ready low 2 cycles -> op/data stable throughout; response held stable until rsp_ready.
- With SCARV_RNG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, RNG never responds -> rsp_valid 8 cycles after entering ISSUE with status 3'b100. A later rng_rsp_valid pulse in IDLE has no effect.
- g_resetn low for one cycle while in WAIT -> next cycle state IDLE, all outputs 0, and requester 0 wins the next tie.

Source files
------------

// File: rtl/scarv_rng_arbiter.sv
// Two-requester round-robin arbiter in front of a single scarv-cpu RNG.
// One transaction in flight; the RNG response is registered and returned
// to the requester that owns the transaction.
// Optional watchdog: define SCARV_RNG_ARB_TIMEOUT_EN to bound the RNG wait
// by TIMEOUT_CYCLES cycles and answer UNHEALTHY on expiry.
module scarv_rng_arbiter #(
  parameter logic [1:0]  SEED_MASK      = 2'b01,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic [1:0]  req_valid,
  input  logic [5:0]  req_op,
  input  logic [63:0] req_data,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  output logic [2:0]  rsp_status,
  output logic [31:0] rsp_data,
  input  logic [1:0]  rsp_ready,
  output logic        rng_req_valid,
  output logic [2:0]  rng_req_op,
  output logic [31:0] rng_req_data,
  input  logic        rng_req_ready,
  input  logic        rng_rsp_valid,
  input  logic [2:0]  rng_rsp_status,
  input  logic [31:0] rng_rsp_data,
  output logic        rng_rsp_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] OP_SEED        = 3'b001;
  localparam logic [2:0] STAT_UNHEALTHY = 3'b100;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic [2:0]  op_q;
  logic [31:0] data_q;
  logic [2:0]  status_q;
  logic [31:0] rdata_q;

  logic        any_req;
  logic        win;
  logic [2:0]  win_op;
  logic [31:0] win_data;
  logic        accept;
  logic        cap_rng;
  logic        cap_fail;
  logic        done;
  logic        timeout;

  assign any_req  = |req_valid;
  assign win_op   = win ? req_op[5:3] : req_op[2:0];
  assign win_data = win ? req_data[63:32] : req_data[31:0];

  // Pick the winner: a lone requester wins, a tie goes away from last_grant.
  always_comb begin
    unique case (req_valid)
      2'b10:   win = 1'b1;
      2'b11:   win = ~last_grant_q;
      default: win = 1'b0;
    endcase
  end

`ifdef SCARV_RNG_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Watchdog: cleared while idle (so zero on entry to ISSUE), counts in ISSUE/WAIT.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      cnt_q <= 16'd0;
    end else if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      cnt_q <= cnt_q + 16'd1;
    end else begin
      cnt_q <= 16'd0;
    end
  end

  // Expire as the counter steps onto the limit; a real response that cycle wins.
  assign timeout = (cnt_q + 16'd1 == TIMEOUT_CYCLES);
`else
  // Limit only matters with the watchdog built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Next-state and capture decisions.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cap_rng  = 1'b0;
    cap_fail = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          accept = 1'b1;
          // Seed from a requester not allowed to seed is refused locally.
          if (win_op == OP_SEED && !SEED_MASK[win]) begin
            cap_fail = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (rng_req_ready && rng_rsp_valid) begin
          cap_rng = 1'b1;
          state_d = ST_RESP;
        end else if (timeout) begin
          cap_fail = 1'b1;
          state_d  = ST_RESP;
        end else if (rng_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rng_rsp_valid) begin
          cap_rng = 1'b1;
          state_d = ST_RESP;
        end else if (timeout) begin
          cap_fail = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[owner_q]) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 3'd0;
      data_q       <= 32'd0;
      status_q     <= 3'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= win;
        op_q    <= win_op;
        data_q  <= win_data;
      end
      if (cap_fail) begin
        status_q <= STAT_UNHEALTHY;
        rdata_q  <= 32'd0;
      end else if (cap_rng) begin
        status_q <= rng_rsp_status;
        rdata_q  <= rng_rsp_data;
      end
      if (done) begin
        last_grant_q <= owner_q;
      end
    end
  end

  // Outputs decoded from state, owner and registers (req_ready also from req_valid).
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    if (state_q == ST_IDLE && any_req) begin
      req_ready[win] = 1'b1;
    end
    if (state_q == ST_RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
    rng_req_valid = (state_q == ST_ISSUE);
    rng_rsp_ready = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    rng_req_op    = op_q;
    rng_req_data  = data_q;
    rsp_status    = status_q;
    rsp_data      = rdata_q;
  end

endmodule

// File: tb/tb_scarv_rng_arbiter.sv
// Directed self-checking bench for scarv_rng_arbiter.
// Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
module tb_scarv_rng_arbiter;

  localparam logic [2:0] OP_SEED = 3'b001;
  localparam logic [2:0] OP_SAMP = 3'b010;
`ifdef SCARV_RNG_ARB_TIMEOUT_EN
  localparam logic [15:0] TO = 16'd8;
`else
  localparam logic [15:0] TO = 16'd255;
`endif

  logic        g_clk;
  logic        g_resetn;
  logic [1:0]  req_valid;
  logic [5:0]  req_op;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [2:0]  rsp_status;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_ready;
  logic        rng_req_valid;
  logic [2:0]  rng_req_op;
  logic [31:0] rng_req_data;
  logic        rng_req_ready;
  logic        rng_rsp_valid;
  logic [2:0]  rng_rsp_status;
  logic [31:0] rng_rsp_data;
  logic        rng_rsp_ready;

  int ntests = 0;
  int nfail  = 0;

  scarv_rng_arbiter #(
    .SEED_MASK      (2'b01),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .g_clk          (g_clk),
    .g_resetn       (g_resetn),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_status     (rsp_status),
    .rsp_data       (rsp_data),
    .rsp_ready      (rsp_ready),
    .rng_req_valid  (rng_req_valid),
    .rng_req_op     (rng_req_op),
    .rng_req_data   (rng_req_data),
    .rng_req_ready  (rng_req_ready),
    .rng_rsp_valid  (rng_rsp_valid),
    .rng_rsp_status (rng_rsp_status),
    .rng_rsp_data   (rng_rsp_data),
    .rng_rsp_ready  (rng_rsp_ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    g_resetn = 1'b0; req_valid = 2'b00; req_op = 6'd0; req_data = 64'd0;
    rsp_ready = 2'b00; rng_req_ready = 1'b0; rng_rsp_valid = 1'b0;
    rng_rsp_status = 3'd0; rng_rsp_data = 32'd0;

    // Reset state
    cyc(); cyc();
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rng_req_valid", rng_req_valid, 1'b0);
    check("rst_rng_rsp_ready", rng_rsp_ready, 1'b0);
    check("rst_rsp_status", rsp_status, 3'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rng_req_op", rng_req_op, 3'd0);
    check("rst_rng_req_data", rng_req_data, 32'd0);
    g_resetn = 1'b1;

    // Zero-latency RNG, single request from requester 0
    cyc();
    req_valid = 2'b01; req_op = {3'd0, OP_SAMP}; rsp_ready = 2'b01;
    rng_req_ready = 1'b1; rng_rsp_valid = 1'b1;
    rng_rsp_status = 3'b101; rng_rsp_data = 32'hDEADBEEF;
    #1;
    check("t1_c0_req_ready", req_ready, 2'b01);
    check("t1_c0_rng_req_valid", rng_req_valid, 1'b0);
    cyc();
    req_valid = 2'b00; #1;
    check("t1_c1_rng_req_valid", rng_req_valid, 1'b1);
    check("t1_c1_rng_req_op", rng_req_op, OP_SAMP);
    check("t1_c1_rsp_valid", rsp_valid, 2'b00);
    cyc(); #1;
    check("t1_c2_rsp_valid", rsp_valid, 2'b01);
    check("t1_c2_rsp_status", rsp_status, 3'b101);
    check("t1_c2_rsp_data", rsp_data, 32'hDEADBEEF);
    cyc(); #1;
    check("t1_c3_rsp_valid", rsp_valid, 2'b00);

    // Round-robin from reset: both valid, six transactions alternate 0,1,...
    g_resetn = 1'b0;
    cyc();
    g_resetn = 1'b1;
    req_valid = 2'b11; req_op = {OP_SAMP, OP_SAMP}; rsp_ready = 2'b11; #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d_req_ready", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc(); #1;
      check($sformatf("rr%0d_issue", i), rng_req_valid, 1'b1);
      cyc(); #1;
      check($sformatf("rr%0d_rsp_valid", i), rsp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      cyc(); #1;
    end
    req_valid = 2'b00; rng_rsp_valid = 1'b0; rng_req_ready = 1'b0;

    // Forbidden seed from requester 1 answered locally
    req_valid = 2'b10; req_op = {OP_SEED, 3'd0}; req_data = {32'h12345678, 32'd0};
    rsp_ready = 2'b10; #1;
    check("seed1_req_ready", req_ready, 2'b10);
    cyc();
    req_valid = 2'b00; #1;
    check("seed1_no_issue", rng_req_valid, 1'b0);
    check("seed1_rsp_valid", rsp_valid, 2'b10);
    check("seed1_rsp_status", rsp_status, 3'b100);
    check("seed1_rsp_data", rsp_data, 32'd0);
    cyc();

    // Same seed from requester 0 is forwarded
    req_valid = 2'b01; req_op = {3'd0, OP_SEED}; req_data = {32'd0, 32'h12345678};
    rsp_ready = 2'b01; rng_req_ready = 1'b1; rng_rsp_valid = 1'b1;
    rng_rsp_status = 3'b101; rng_rsp_data = 32'h0; #1;
    check("seed0_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00; #1;
    check("seed0_issue", rng_req_valid, 1'b1);
    check("seed0_op", rng_req_op, OP_SEED);
    check("seed0_data", rng_req_data, 32'h12345678);
    cyc(); #1;
    check("seed0_rsp_valid", rsp_valid, 2'b01);
    check("seed0_rsp_status", rsp_status, 3'b101);
    cyc();

    // Slow RNG: request held 3 cycles, response 4 cycles after acceptance
    req_valid = 2'b01; req_op = {3'd0, OP_SAMP}; req_data = 64'd0;
    rsp_ready = 2'b00; rng_req_ready = 1'b0; rng_rsp_valid = 1'b0;
    rng_rsp_status = 3'b101; rng_rsp_data = 32'hCAFEF00D; #1;
    check("slow_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b10; req_op = {OP_SAMP, 3'd0};
    for (int c = 1; c <= 4; c++) begin
      rng_req_ready = (c == 4); #1;
      check($sformatf("slow_c%0d_issue", c), rng_req_valid, 1'b1);
      check($sformatf("slow_c%0d_op", c), rng_req_op, OP_SAMP);
      check($sformatf("slow_c%0d_nonowner", c), req_ready, 2'b00);
      cyc();
    end
    rng_req_ready = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      rng_rsp_valid = (c == 8); #1;
      check($sformatf("slow_c%0d_wait", c), {rng_req_valid, rng_rsp_ready}, 2'b01);
      check($sformatf("slow_c%0d_rsp_valid", c), rsp_valid, 2'b00);
      cyc();
    end
    rng_rsp_valid = 1'b0; rng_rsp_data = 32'h0;
    for (int c = 9; c <= 11; c++) begin
      rsp_ready = (c == 11) ? 2'b01 : 2'b00; #1;
      check($sformatf("slow_c%0d_rsp_valid", c), rsp_valid, 2'b01);
      check($sformatf("slow_c%0d_rsp_data", c), rsp_data, 32'hCAFEF00D);
      check($sformatf("slow_c%0d_rsp_status", c), rsp_status, 3'b101);
      check($sformatf("slow_c%0d_nonowner", c), req_ready, 2'b00);
      cyc();
    end
    req_valid = 2'b00; rsp_ready = 2'b00; #1;
    check("slow_c12_idle", rsp_valid, 2'b00);

`ifdef SCARV_RNG_ARB_TIMEOUT_EN
    // Watchdog: RNG accepts but never responds
    req_valid = 2'b01; req_op = {3'd0, OP_SAMP}; rsp_ready = 2'b01;
    rng_req_ready = 1'b1; rng_rsp_valid = 1'b0; #1;
    check("to_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      #1;
      check($sformatf("to_c%0d_rsp_valid", c), rsp_valid, 2'b00);
      cyc();
    end
    #1;
    check("to_c9_rsp_valid", rsp_valid, 2'b01);
    check("to_c9_rsp_status", rsp_status, 3'b100);
    check("to_c9_rsp_data", rsp_data, 32'd0);
    cyc();
    rng_rsp_valid = 1'b1; rng_rsp_data = 32'h55AA55AA; rng_rsp_status = 3'b101; #1;
    check("to_stray_rsp_ready", rng_rsp_ready, 1'b0);
    cyc();
    rng_rsp_valid = 1'b0; #1;
    check("to_stray_rsp_valid", rsp_valid, 2'b00);
    check("to_stray_rsp_data", rsp_data, 32'd0);
    rng_req_ready = 1'b0;
`endif

    // Reset while in WAIT
    req_valid = 2'b01; req_op = {3'd0, OP_SAMP}; rsp_ready = 2'b00;
    rng_req_ready = 1'b1; rng_rsp_valid = 1'b0; rng_rsp_data = 32'h0; #1;
    check("rw_req_ready", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00; #1;
    check("rw_issue", rng_req_valid, 1'b1);
    cyc();
    rng_req_ready = 1'b0; #1;
    check("rw_wait", {rng_req_valid, rng_rsp_ready}, 2'b01);
    g_resetn = 1'b0;
    cyc(); #1;
    check("rw_rng_rsp_ready", rng_rsp_ready, 1'b0);
    check("rw_rng_req_valid", rng_req_valid, 1'b0);
    check("rw_rsp_valid", rsp_valid, 2'b00);
    check("rw_rsp_status", rsp_status, 3'd0);
    check("rw_rng_req_op", rng_req_op, 3'd0);
    g_resetn = 1'b1; req_valid = 2'b11; req_op = {OP_SAMP, OP_SAMP}; #1;
    check("rw_tie_after_reset", req_ready, 2'b01);
    cyc();
    req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
